// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ requesters.
// Grants in IDLE, holds the start handshake, and reports Ack/Err per requester.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_BITS     = 8,
  parameter int START_TIMEOUT = 4096,
  localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         SysClk,
  input  logic                         Rst,
  input  logic [NUM_REQ-1:0]           Req,
  input  logic [NUM_REQ*DATA_BITS-1:0] Req_Data,
  output logic [NUM_REQ-1:0]           Ack,
  output logic [NUM_REQ-1:0]           Err,
  input  logic                         BIST_Busy,
  input  logic                         Tx_Busy,
  output logic [DATA_BITS-1:0]         Tx_Data,
  output logic                         Transmit_Start,
  output logic [ID_W-1:0]              Grant_Id,
  output logic                         Arb_Busy
);

  localparam int CNT_W = $clog2(START_TIMEOUT) + 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] BUSY  = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] FAIL  = 3'd4;

  logic [2:0]       state;
  logic [ID_W-1:0]  ptr;
  logic [CNT_W-1:0] cnt;
  logic             busy_meta;
  logic             busy_s;

  logic             found;
  logic [ID_W-1:0]  winner;
  int               idx;

  // Tx_Busy comes from the baud-clock domain; only busy_s may steer the FSM.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge SysClk or negedge Rst) begin
    if (!Rst) begin
      busy_meta <= 1'b0;
      busy_s    <= 1'b0;
    end else begin
      busy_meta <= Tx_Busy;
      busy_s    <= busy_meta;
    end
  end

  // Search upward from ptr+1 with wrap, so the last served requester is last.
  // NOTE: every variable gets a default before the loop; without it the
  // no-request path would infer a latch.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!found && Req[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge SysClk or negedge Rst) begin
    if (!Rst) begin
      state          <= IDLE;
      ptr            <= ID_W'(NUM_REQ - 1);
      cnt            <= '0;
      Grant_Id       <= '0;
      Tx_Data        <= '0;
      Transmit_Start <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found && !BIST_Busy) begin
            Grant_Id       <= winner;
            Tx_Data        <= Req_Data[int'(winner)*DATA_BITS +: DATA_BITS];
            Transmit_Start <= 1'b1;
            cnt            <= '0;
            state          <= START;
          end
        end
        START: begin
          cnt <= cnt + 1'b1;
          // A busy indication on the timeout cycle still counts as success.
          if (busy_s) begin
            Transmit_Start <= 1'b0;
            state          <= BUSY;
          end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
            Transmit_Start <= 1'b0;
            state          <= FAIL;
          end
        end
        BUSY: begin
          if (!busy_s) state <= DONE;
        end
        DONE, FAIL: begin
          ptr   <= Grant_Id;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Responses decode straight from state, so reset clears them with no edge.
  always_comb begin
    Ack = '0;
    Err = '0;
    if (state == DONE) Ack[Grant_Id] = 1'b1;
    if (state == FAIL) Err[Grant_Id] = 1'b1;
  end

  assign Arb_Busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a background Tx_Busy model and
// hand-computed expectations for grant order, timeouts, BIST and reset.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_BITS = 8;
  localparam int T_OUT = 64;

  logic                         SysClk = 1'b0;
  logic                         Rst = 1'b0;
  logic [NUM_REQ-1:0]           Req = '0;
  logic [NUM_REQ*DATA_BITS-1:0] Req_Data = '0;
  logic [NUM_REQ-1:0]           Ack;
  logic [NUM_REQ-1:0]           Err;
  logic                         BIST_Busy = 1'b0;
  logic                         Tx_Busy = 1'b0;
  logic [DATA_BITS-1:0]         Tx_Data;
  logic                         Transmit_Start;
  logic [1:0]                   Grant_Id;
  logic                         Arb_Busy;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_BITS(DATA_BITS), .START_TIMEOUT(T_OUT)
  ) dut (
    .SysClk(SysClk), .Rst(Rst), .Req(Req), .Req_Data(Req_Data),
    .Ack(Ack), .Err(Err), .BIST_Busy(BIST_Busy), .Tx_Busy(Tx_Busy),
    .Tx_Data(Tx_Data), .Transmit_Start(Transmit_Start),
    .Grant_Id(Grant_Id), .Arb_Busy(Arb_Busy)
  );

  always #5 SysClk = ~SysClk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Cycle counter and passive monitor.
  int cyc = 0;
  int grant_cnt = 0;
  int ts_len = 0;
  int fall_cyc = 0;
  int rise_cyc = 0;
  int bad_hot = 0;
  bit ts_prev = 1'b0;

  always @(posedge SysClk) cyc++;

  always @(negedge SysClk) begin
    if (Transmit_Start && !ts_prev) begin
      grant_cnt++;
      ts_len = 0;
    end
    if (Transmit_Start) ts_len++;
    if (!Transmit_Start && ts_prev) fall_cyc = cyc;
    ts_prev = Transmit_Start;
    if ($countones({Ack, Err}) > 1) bad_hot++;
  end

  // Transmitter model: goes busy busy_delay cycles after seeing Transmit_Start.
  bit model_en = 1'b1;
  int busy_delay = 2;
  int busy_len = 5;

  initial begin
    forever begin
      @(negedge SysClk);
      if (model_en && Transmit_Start) begin
        repeat (busy_delay) @(negedge SysClk);
        Tx_Busy = 1'b1;
        rise_cyc = cyc;
        repeat (busy_len) @(negedge SysClk);
        Tx_Busy = 1'b0;
      end
    end
  end

  task automatic wait_grant(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc && !Transmit_Start; i++) @(negedge SysClk);
    check(tag, Transmit_Start, 1);
  endtask

  task automatic wait_resp(input int max_cyc, output logic [NUM_REQ-1:0] ack,
                           output logic [NUM_REQ-1:0] err);
    ack = '0;
    err = '0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge SysClk);
      if ((Ack | Err) != '0) begin
        ack = Ack;
        err = Err;
        return;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [NUM_REQ-1:0] ack, err;
  int g0;
  int exp_id [5] = '{0, 1, 2, 3, 0};
  logic [7:0] exp_byte [5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};

  initial begin
    // Reset state
    @(negedge SysClk);
    check("rst_ts", Transmit_Start, 0);
    check("rst_arb_busy", Arb_Busy, 0);
    check("rst_ack_err", {Ack, Err}, 0);
    check("rst_grant", Grant_Id, 0);
    check("rst_data", Tx_Data, 0);
    Rst = 1'b1;
    @(negedge SysClk);

    // 1: single transfer, one-cycle grant latency, synchroniser delay
    busy_delay = 20;
    busy_len = 200;
    Req_Data[7:0] = 8'hA5;
    Req = 4'b0001;
    check("t1_ts_before", Transmit_Start, 0);
    @(negedge SysClk);
    check("t1_ts_latency", Transmit_Start, 1);
    check("t1_grant", Grant_Id, 0);
    check("t1_data", Tx_Data, 8'hA5);
    wait_resp(400, ack, err);
    check("t1_ack", ack, 4'b0001);
    check("t1_err", err, 0);
    check("t1_drop_lat", fall_cyc - rise_cyc, 3);
    Req = '0;
    @(negedge SysClk);
    check("t1_ack_pulse", Ack, 0);

    // Restart pointer so requester 0 leads the round-robin sweep
    Rst = 1'b0;
    @(negedge SysClk);
    Rst = 1'b1;

    // 2: round robin with all requesters active
    busy_delay = 2;
    busy_len = 5;
    Req_Data = {8'h43, 8'h32, 8'h21, 8'h10};
    Req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_resp(100, ack, err);
      check($sformatf("t2_ack%0d", k), ack, 4'b0001 << exp_id[k]);
      check($sformatf("t2_grant%0d", k), Grant_Id, exp_id[k]);
      check($sformatf("t2_data%0d", k), Tx_Data, exp_byte[k]);
      Req[exp_id[k]] = 1'b0;
      @(negedge SysClk);
      Req[exp_id[k]] = 1'b1;
    end
    Req = '0;
    repeat (30) @(negedge SysClk);

    // 3: start timeout, then fairness after a failure
    model_en = 1'b0;
    Req = 4'b0100;
    wait_resp(T_OUT + 20, ack, err);
    check("t3_err", err, 4'b0100);
    check("t3_ack", ack, 0);
    check("t3_ts_len", ts_len, T_OUT);
    Req = '0;
    @(negedge SysClk);
    check("t3_err_pulse", Err, 0);
    @(negedge SysClk);
    g0 = grant_cnt;
    Req = 4'b0100;
    wait_grant("t3b_grant2", 10);
    check("t3b_grant_id", Grant_Id, 2);
    @(negedge SysClk);
    Req = 4'b0110;
    wait_resp(T_OUT + 20, ack, err);
    check("t3b_err", err, 4'b0100);
    check("t3b_no_preempt", grant_cnt - g0, 1);
    Req = 4'b0010;
    model_en = 1'b1;
    wait_grant("t3b_grant1", 10);
    check("t3b_next_id", Grant_Id, 1);
    wait_resp(100, ack, err);
    check("t3b_ack1", ack, 4'b0010);
    Req = '0;
    repeat (5) @(negedge SysClk);

    // 4: BIST blocks grants but not a transfer in flight
    BIST_Busy = 1'b1;
    Req = 4'b0010;
    g0 = grant_cnt;
    repeat (500) @(negedge SysClk);
    check("t4_blocked", grant_cnt - g0, 0);
    check("t4_idle", Arb_Busy, 0);
    BIST_Busy = 1'b0;
    @(negedge SysClk);
    check("t4_grant_next", Transmit_Start, 1);
    check("t4_grant_id", Grant_Id, 1);
    busy_len = 20;
    repeat (8) @(negedge SysClk);
    BIST_Busy = 1'b1;
    wait_resp(100, ack, err);
    check("t4_ack", ack, 4'b0010);
    Req = '0;
    BIST_Busy = 1'b0;
    repeat (5) @(negedge SysClk);

    // 5: asynchronous reset mid-BUSY
    busy_len = 30;
    Req = 4'b0001;
    wait_grant("t5_grant0", 10);
    repeat (8) @(negedge SysClk);
    check("t5_in_busy", Arb_Busy, 1);
    Req = 4'b1000;
    #2 Rst = 1'b0;
    #1;
    check("t5_rst_ts", Transmit_Start, 0);
    check("t5_rst_arb", Arb_Busy, 0);
    check("t5_rst_data", Tx_Data, 0);
    check("t5_rst_grant", Grant_Id, 0);
    @(negedge SysClk);
    Rst = 1'b1;
    @(negedge SysClk);
    check("t5_grant3", Transmit_Start, 1);
    check("t5_grant_id", Grant_Id, 3);
    check("t5_data", Tx_Data, 8'h43);
    wait_resp(100, ack, err);
    check("t5_ack", ack, 4'b1000);
    Req = '0;
    repeat (5) @(negedge SysClk);

    // 6: requester drops Req right after its grant
    busy_len = 10;
    Req = 4'b0001;
    wait_grant("t6_grant", 10);
    g0 = grant_cnt;
    @(negedge SysClk);
    Req = '0;
    wait_resp(100, ack, err);
    check("t6_ack", ack, 4'b0001);
    g0 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge SysClk);
      if (Ack != '0 || Transmit_Start) g0++;
    end
    check("t6_no_regrant", g0, 0);

    check("ack_err_onehot", bad_hot, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares the single UART transmitter (Tx_Data / Transmit_Start / Tx_Busy) between NUM_REQ on-chip requesters. Latches the granted requester's byte and drives the transmitter's start handshake in the SysClk domain. Tracks completion through a synchronised Tx_Busy and returns a per-requester Ack or Err. Sits between client logic and the UART top-level transmit inputs, and yields the transmitter whenever BIST is running.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_BITS, 8, width of one transmitted character; matches the UART DATA_BITS
START_TIMEOUT, 4096, SysClk cycles to wait for synchronised Tx_Busy to rise after Transmit_Start before flagging an error

Ports:
SysClk  in  1  system clock; all logic in this block is on this clock
Rst  in  1  asynchronous, active-low reset
Req  in  NUM_REQ  per-requester level request; held until that requester's Ack or Err
Req_Data  in  NUM_REQ*DATA_BITS  requester i's byte at bits [i*DATA_BITS +: DATA_BITS]
Ack  out  NUM_REQ  one-cycle pulse: requester's byte fully transmitted
Err  out  NUM_REQ  one-cycle pulse: transmitter never went busy (timeout)
BIST_Busy  in  1  UART self-test active; no new grants while high
Tx_Busy  in  1  transmitter busy, from the baud-clock domain (asynchronous to SysClk)
Tx_Data  out  DATA_BITS  byte presented to the transmitter
Transmit_Start  out  1  transmit request to the transmitter (level, held)
Grant_Id  out  $clog2(NUM_REQ)  index of the current or last granted requester
Arb_Busy  out  1  high in every state except IDLE

Behaviour:
- Reset (Rst low, asynchronous):
  - State IDLE; Ack=0, Err=0, Transmit_Start=0, Tx_Data=0, Grant_Id=0, Arb_Busy=0.
  - Round-robin pointer set to NUM_REQ-1, so requester 0 has first priority.
  - Synchroniser flops and timeout counter cleared.
- Tx_Busy passes through a 2-flop synchroniser (Tx_Busy_s). All FSM decisions use Tx_Busy_s only.
- FSM states: IDLE, START, BUSY, DONE, FAIL.
- IDLE:
  - If any Req bit is set and BIST_Busy=0, grant the first set bit searching upward from pointer+1 with wrap-around.
  - On the next edge: Grant_Id=winner, Tx_Data=Req_Data slice of the winner, Transmit_Start=1, timeout counter=0, state=START.
  - Latency is one SysClk from Req sampled to Transmit_Start high.
- START:
  - Hold Transmit_Start and Tx_Data stable; increment the counter each cycle.
  - If Tx_Busy_s=1: Transmit_Start=0, state=BUSY.
  - Else if counter reaches START_TIMEOUT-1: Transmit_Start=0, state=FAIL.
  - If Tx_Busy_s=1 on the same cycle as the timeout, Tx_Busy_s wins (go to BUSY).
- BUSY: wait for Tx_Busy_s=0, then go to DONE. No timeout in this state.
- DONE: Ack[Grant_Id]=1 for exactly one cycle; pointer=Grant_Id; next state IDLE.
- FAIL: Err[Grant_Id]=1 for exactly one cycle; pointer=Grant_Id, so the failing requester does not monopolise; next state IDLE.
- At most one Ack/Err bit is set in any cycle. Ack and Err are never set together.
- Back-to-back transfers have a minimum gap of one IDLE cycle between DONE and the next grant.
- Tx_Data holds the last granted byte until the next grant.
- A requester dropping Req after grant does not abort the transfer. Its Ack/Err still pulses, and the requester ignores it.
- Req changes while the arbiter is not in IDLE have no effect until IDLE.
- BIST_Busy rising mid-transfer does not abort the transfer; it only blocks grants in IDLE.
- NUM_REQ=1 degenerates to a pass-through sequencer; Grant_Id is held at 0.

Test Plan:
1. Reset release; Req=4'b0001, Req_Data[7:0]=8'hA5; model Tx_Busy high 20 cycles after start for 200 cycles -> Transmit_Start high 1 cycle after Req, drops 2–3 cycles after Tx_Busy rises; Tx_Data=8'hA5; Ack=4'b0001 for one cycle; Grant_Id=0.
2. Req=4'b1111 held with distinct bytes 8'h10, 8'h21, 8'h32, 8'h43; re-assert each requester after its Ack -> grant order 0,1,2,3,0; bytes on Tx_Data in that order; never two Ack bits in one cycle.
3. Req=4'b0100, Tx_Busy tied 0 -> Transmit_Start held exactly START_TIMEOUT cycles, then Err=4'b0100 for one cycle, Ack stays 0. Repeat with Req=4'b0110 -> requester 1 is not granted before requester 2's Err; requester 1 is granted next.
4. BIST_Busy=1 and Req=4'b0010 -> no Transmit_Start for 500 cycles. Drop BIST_Busy -> grant on the next cycle. Raise BIST_Busy during BUSY -> the transfer completes with Ack.
5. Assert Rst low mid-BUSY -> all outputs 0 immediately, without waiting for a clock edge. Release with Req=4'b1000 -> requester 3 is granted, pointer restarts at NUM_REQ-1.
6. Req[0] dropped one cycle after grant -> the transfer still completes; Ack[0] pulses once; no re-grant to requester 0 unless Req[0] is reasserted.
